fractal_sync_join: RTL

//  Merge stage downstream of the left/right rx FIFOs of one fractal-sync node. Pops one head from each side only when

---
 rtl/fractal_sync_pkg.sv | 31 +++
 rtl/fractal_sync_join_timer.sv | 35 +++
 rtl/fractal_sync_join.sv | 97 +++++++++
 3 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal-sync node: request layout, join FSM states and the destination merge.
package fractal_sync_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned AGGR_W = 2;
  localparam int unsigned DST_W  = 4;

  typedef struct packed {
    logic [AGGR_W-1:0] aggr;
    logic [ID_W-1:0]   id;
  } fsync_sig_t;

  typedef struct packed {
    logic             sync;
    fsync_sig_t       sig;
    logic [DST_W-1:0] dst;
  } fsync_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_L,
    WAIT_R,
    SEND
  } join_state_e;

  function automatic logic [DST_W-1:0] fsync_join_dst(input logic [DST_W-1:0] dst_l,
                                                      input logic [DST_W-1:0] dst_r);
    return dst_l | dst_r;
  endfunction

endpackage

// File: rtl/fractal_sync_join_timer.sv
// Saturating single-side wait counter with a sticky timeout flag; only built with FRACTAL_SYNC_JOIN_TIMEOUT_EN.
module fractal_sync_join_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!wait_i) begin
        r_cnt <= '0;
      end else if (r_cnt != LIMIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt == LIMIT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;

endmodule

// File: rtl/fractal_sync_join.sv
// Joins left/right rx FIFO heads of one fractal-sync node into a single registered request.
// Optional single-side wait timeout enabled by defining FRACTAL_SYNC_JOIN_TIMEOUT_EN.
module fractal_sync_join
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_req_t    = fractal_sync_pkg::fsync_req_t,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       empty_l_i,
  input  fsync_req_t req_l_i,
  output logic       pop_l_o,
  input  logic       empty_r_i,
  input  fsync_req_t req_r_i,
  output logic       pop_r_o,
  output logic       valid_o,
  output fsync_req_t req_o,
  input  logic       ready_i,
  output logic       error_mismatch_o,
  output logic       error_timeout_o
);

  join_state_e r_state;
  logic        r_valid;
  fsync_req_t  r_req;

  logic       w_eval;
  logic       w_both;
  logic       w_match;
  logic       w_pop;
  fsync_req_t w_merged;
  logic       w_unused;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("fractal_sync_join: TIMEOUT_CYCLES must be greater than zero");
  end

  assign w_eval  = (r_state != SEND) || ready_i;
  assign w_both  = !empty_l_i && !empty_r_i;
  assign w_match = (req_l_i.sig.id == req_r_i.sig.id) && (req_l_i.sig.aggr == req_r_i.sig.aggr);
  // Gated by reset so the FIFOs are never popped while the join is held in reset.
  assign w_pop   = rst_ni && w_eval && w_both;

  assign pop_l_o          = w_pop;
  assign pop_r_o          = w_pop;
  assign error_mismatch_o = w_pop && !w_match;
  assign w_unused         = req_l_i.sync ^ req_r_i.sync;

  always_comb begin
    w_merged      = '0;
    w_merged.sync = 1'b1;
    w_merged.sig  = req_l_i.sig;
    w_merged.dst  = fsync_join_dst(req_l_i.dst, req_r_i.dst);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (w_eval) begin
      if (w_both && w_match) begin
        r_state <= SEND;
        r_valid <= 1'b1;
        r_req   <= w_merged;
      end else begin
        r_valid <= 1'b0;
        r_req   <= '0;
        if (w_both || (empty_l_i && empty_r_i)) begin
          r_state <= IDLE;
        end else if (empty_l_i) begin
          r_state <= WAIT_L;
        end else begin
          r_state <= WAIT_R;
        end
      end
    end
  end

  assign valid_o = r_valid;
  assign req_o   = r_req;

`ifdef FRACTAL_SYNC_JOIN_TIMEOUT_EN
  fractal_sync_join_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wait_i   ((r_state == WAIT_L) || (r_state == WAIT_R)),
    .timeout_o(error_timeout_o)
  );
`else
  assign error_timeout_o = 1'b0;
`endif

endmodule
